mu0_mem_ws: RTL and testbench

MU0_MEM_WS -- requirements
Module: mu0_mem_ws

---
 rtl/mu0_mem_pkg.sv | 17 +
 rtl/mu0_mem_ws_if.sv | 43 ++++
 rtl/mu0_mem_array.sv | 32 +++
 rtl/mu0_mem_ws.sv | 158 +++++++++++++++
 tb/tb_mu0_mem_ws.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/mu0_mem_pkg.sv
// mu0_mem_pkg: shared state type and default constants for the MU0 wait-state memory.
package mu0_mem_pkg;

  localparam logic [15:0] DEF_FILL        = 16'h5555;
  localparam logic [15:0] DEF_IDLE_DATA   = 16'hBFBF;
  localparam int          DEF_WAIT_CYCLES = 2;

  // Wait-state counter width, enough for 0..15 wait states.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/mu0_mem_ws_if.sv
// mu0_mem_ws_if: request/acknowledge bus between the MU0 core and its wait-state memory.
// With MU0_MEM_ERR_EN defined the bus also carries the err pulse.
interface mu0_mem_ws_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LED_W  = 6
);

  logic              memRq;
  logic              readNotWrite;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataIn;
  logic [DATA_W-1:0] dataOut;
  logic              memAck;
  logic              busy;
  logic [LED_W-1:0]  led;
`ifdef MU0_MEM_ERR_EN
  logic              err;
`endif

`ifdef MU0_MEM_ERR_EN
  modport master (
    output memRq, readNotWrite, addr, dataIn,
    input  dataOut, memAck, busy, led, err
  );

  modport slave (
    input  memRq, readNotWrite, addr, dataIn,
    output dataOut, memAck, busy, led, err
  );
`else
  modport master (
    output memRq, readNotWrite, addr, dataIn,
    input  dataOut, memAck, busy, led
  );

  modport slave (
    input  memRq, readNotWrite, addr, dataIn,
    output dataOut, memAck, busy, led
  );
`endif

endinterface

// File: rtl/mu0_mem_array.sv
// mu0_mem_array: DEPTH x DATA_W storage with one synchronous write port,
// one asynchronous read port and a tap on the low bits of word 0 for the LEDs.
// Contents come up as FILL and are never cleared by reset.
module mu0_mem_array #(
  parameter int                DATA_W = 16,
  parameter int                DEPTH  = 32,
  parameter int                IDX_W  = $clog2(DEPTH),
  parameter int                TAP_W  = 6,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_wIdx,
  input  logic [DATA_W-1:0] i_wData,
  input  logic [IDX_W-1:0]  i_rIdx,
  output logic [DATA_W-1:0] o_rData,
  output logic [TAP_W-1:0]  o_word0Tap
);

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: FILL};

  // Single write port, committed on the clock edge that enables it.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wIdx] <= i_wData;
    end
  end

  assign o_rData    = r_mem[i_rIdx];
  assign o_word0Tap = r_mem[0][TAP_W-1:0];

endmodule

// File: rtl/mu0_mem_ws.sv
// mu0_mem_ws: MU0 data memory with a fixed number of wait states per access.
// A request is captured in IDLE, waits WAIT_CYCLES cycles, then completes with a
// one-cycle memAck. The array write and the read-data register both happen on the
// edge that enters ACK, so an access aborted by reset leaves memory untouched.
// Optional feature: define MU0_MEM_ERR_EN to flag out-of-range addresses on err
// (such writes are dropped and such reads return IDLE_DATA); otherwise addresses wrap.
module mu0_mem_ws
  import mu0_mem_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH       = 32,
  parameter int                WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [DATA_W-1:0] FILL        = DATA_W'(DEF_FILL),
  parameter logic [DATA_W-1:0] IDLE_DATA   = DATA_W'(DEF_IDLE_DATA),
  parameter int                LED_W       = 6
) (
  input logic         clk,
  input logic         rst_n,
  mu0_mem_ws_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rnw;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_wData;
  logic               r_memAck;
  logic               r_busy;
  logic [DATA_W-1:0]  r_dataOut;
`ifdef MU0_MEM_ERR_EN
  logic               r_oor;
  logic               r_err;
`endif

  logic               w_start;
  logic               w_enterAck;
  logic               w_rnw;
  logic               w_oor;
  logic               w_we;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_wData;
  logic [DATA_W-1:0]  w_rData;
  logic [DATA_W-1:0]  w_ackData;
  logic [LED_W-1:0]   w_word0Tap;

  // Select the live bus fields in IDLE (zero-wait access completes on the capture edge)
  // and the captured fields otherwise, and decide whether this edge enters ACK.
  always_comb begin
    w_start    = (r_state == IDLE) && bus.memRq;
    w_enterAck = (w_start && (WAIT_CYCLES == 0)) ||
                 ((r_state == WAIT) && (r_cnt == CNT_W'(1)));
    if (r_state == IDLE) begin
      w_rnw   = bus.readNotWrite;
      w_idx   = bus.addr[IDX_W-1:0];
      w_wData = bus.dataIn;
    end else begin
      w_rnw   = r_rnw;
      w_idx   = r_idx;
      w_wData = r_wData;
    end
`ifdef MU0_MEM_ERR_EN
    w_oor = (r_state == IDLE) ? ((bus.addr >> IDX_W) != '0) : r_oor;
`else
    w_oor = 1'b0;
`endif
    w_we = rst_n && w_enterAck && !w_rnw && !w_oor;
  end

  assign w_ackData = (w_rnw && !w_oor) ? w_rData : IDLE_DATA;

  mu0_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .TAP_W  (LED_W),
    .FILL   (FILL)
  ) u_array (
    .clk        (clk),
    .i_we       (w_we),
    .i_wIdx     (w_idx),
    .i_wData    (w_wData),
    .i_rIdx     (w_idx),
    .o_rData    (w_rData),
    .o_word0Tap (w_word0Tap)
  );

  // Access FSM with registered memAck, busy, dataOut (and err) outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rnw     <= 1'b1;
      r_idx     <= '0;
      r_wData   <= '0;
      r_memAck  <= 1'b0;
      r_busy    <= 1'b0;
      r_dataOut <= IDLE_DATA;
`ifdef MU0_MEM_ERR_EN
      r_oor     <= 1'b0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_memAck  <= 1'b0;
      r_dataOut <= IDLE_DATA;
`ifdef MU0_MEM_ERR_EN
      r_err     <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.memRq) begin
            r_rnw   <= bus.readNotWrite;
            r_idx   <= bus.addr[IDX_W-1:0];
            r_wData <= bus.dataIn;
`ifdef MU0_MEM_ERR_EN
            r_oor   <= w_oor;
`endif
            r_state <= WAIT;
            r_cnt   <= CNT_W'(WAIT_CYCLES);
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
        ACK: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_enterAck) begin
        r_state   <= ACK;
        r_cnt     <= '0;
        r_memAck  <= 1'b1;
        r_busy    <= 1'b1;
        r_dataOut <= w_ackData;
`ifdef MU0_MEM_ERR_EN
        r_err     <= w_oor;
`endif
      end
    end
  end

  assign bus.memAck  = r_memAck;
  assign bus.busy    = r_busy;
  assign bus.dataOut = r_dataOut;
  assign bus.led     = ~w_word0Tap;
`ifdef MU0_MEM_ERR_EN
  assign bus.err     = r_err;
`endif

endmodule

// File: tb/tb_mu0_mem_ws.sv
// tb_mu0_mem_ws: scoreboard bench for mu0_mem_ws. dutA uses the default two wait
// states, dutB uses zero wait states for back-to-back traffic.
module tb_mu0_mem_ws;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

`ifdef MU0_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mu0_mem_ws_if #(.DATA_W(16), .ADDR_W(16), .LED_W(6)) busA ();
  mu0_mem_ws_if #(.DATA_W(16), .ADDR_W(16), .LED_W(6)) busB ();

  mu0_mem_ws #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(32), .WAIT_CYCLES(2),
    .FILL(16'h5555), .IDLE_DATA(16'hBFBF), .LED_W(6)
  ) dutA (.clk(clk), .rst_n(rst_n), .bus(busA));

  mu0_mem_ws #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(32), .WAIT_CYCLES(0),
    .FILL(16'h5555), .IDLE_DATA(16'hBFBF), .LED_W(6)
  ) dutB (.clk(clk), .rst_n(rst_n), .bus(busB));

  string       qAName[$];
  bit          qARd[$];
  logic [15:0] qAData[$];
  bit          qAErr[$];
  string       qBName[$];
  bit          qBRd[$];
  logic [15:0] qBData[$];
  bit          qBErr[$];

  string       monAName, monBName;
  bit          monARd, monBRd, monAErr, monBErr;
  logic [15:0] monAData, monBData;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor for dutA: every memAck pops and checks one expected completion.
  always @(negedge clk) begin
    if (rst_n && busA.memAck === 1'b1) begin
      if (qAName.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL A_spurious_ack: got memAck=1 expected no completion");
      end else begin
        monAName = qAName.pop_front();
        monARd   = qARd.pop_front();
        monAData = qAData.pop_front();
        monAErr  = qAErr.pop_front();
        if (monARd) checkOutput({monAName, "_data"}, busA.dataOut, monAData);
`ifdef MU0_MEM_ERR_EN
        checkOutput({monAName, "_err"}, busA.err, monAErr);
`endif
      end
    end
  end

  // Monitor for dutB: same scoreboard discipline on the zero-wait instance.
  always @(negedge clk) begin
    if (rst_n && busB.memAck === 1'b1) begin
      if (qBName.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL B_spurious_ack: got memAck=1 expected no completion");
      end else begin
        monBName = qBName.pop_front();
        monBRd   = qBRd.pop_front();
        monBData = qBData.pop_front();
        monBErr  = qBErr.pop_front();
        if (monBRd) checkOutput({monBName, "_data"}, busB.dataOut, monBData);
`ifdef MU0_MEM_ERR_EN
        checkOutput({monBName, "_err"}, busB.err, monBErr);
`endif
      end
    end
  end

  task automatic driveA(input string name, input bit rd, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] expData, input bit expErr);
    busA.memRq        = 1'b1;
    busA.readNotWrite = rd;
    busA.addr         = a;
    busA.dataIn       = d;
    qAName.push_back(name);
    qARd.push_back(rd);
    qAData.push_back(expData);
    qAErr.push_back(expErr);
  endtask

  task automatic waitAckA(input string name, input int expLat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) checkOutput({name, "_busyWait"}, busA.busy, 1);
    end while (busA.memAck !== 1'b1 && n < 20);
    checkOutput({name, "_ack"}, busA.memAck, 1);
    checkOutput({name, "_latency"}, n, expLat);
  endtask

  task automatic applyStimulus(input string name, input bit rd, input logic [15:0] a,
                               input logic [15:0] d, input logic [15:0] expData,
                               input bit expErr);
    @(negedge clk);
    driveA(name, rd, a, d, expData, expErr);
    waitAckA(name, 3);
    busA.memRq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          rdV [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] adV [5] = '{16'd2, 16'd0, 16'd1, 16'd2, 16'd3};
    logic [15:0] dtV [5] = '{16'h2222, 16'h0, 16'h0, 16'h0, 16'h0};
    logic [15:0] exV [5] = '{16'h0000, 16'h5555, 16'h5555, 16'h2222, 16'h5555};
    int          n;

    busA.memRq = 1'b0; busA.readNotWrite = 1'b1; busA.addr = '0; busA.dataIn = '0;
    busB.memRq = 1'b0; busB.readNotWrite = 1'b1; busB.addr = '0; busB.dataIn = '0;
    repeat (3) @(negedge clk);

    checkOutput("rst_memAck", busA.memAck, 0);
    checkOutput("rst_busy", busA.busy, 0);
    checkOutput("rst_dataOut", busA.dataOut, 16'hBFBF);
    checkOutput("rst_led", busA.led, 6'b101010);
    checkOutput("rstB_dataOut", busB.dataOut, 16'hBFBF);
    rst_n = 1'b1;

    applyStimulus("rdA3", 1'b1, 16'd3, 16'h0, 16'h5555, 1'b0);
    checkOutput("rdA3_led", busA.led, 6'b101010);

    applyStimulus("wrA0", 1'b0, 16'd0, 16'h00FF, 16'h0, 1'b0);
    checkOutput("wrA0_ledAtAck", busA.led, 6'b000000);
    applyStimulus("rdA0", 1'b1, 16'd0, 16'h0, 16'h00FF, 1'b0);

    applyStimulus("wrA33", 1'b0, 16'd33, 16'h1234, 16'h0, ERR_EN);
    applyStimulus("rdA1", 1'b1, 16'd1, 16'h0, ERR_EN ? 16'h5555 : 16'h1234, 1'b0);
    applyStimulus("rdA33", 1'b1, 16'd33, 16'h0, ERR_EN ? 16'hBFBF : 16'h1234, ERR_EN);

    @(negedge clk);
    driveA("capW7", 1'b0, 16'd7, 16'h7777, 16'h0, 1'b0);
    @(negedge clk);
    busA.addr = 16'd8; busA.dataIn = 16'h8888; busA.readNotWrite = 1'b1;
    waitAckA("capW7", 2);
    busA.memRq = 1'b0;
    applyStimulus("rdA7", 1'b1, 16'd7, 16'h0, 16'h7777, 1'b0);
    applyStimulus("rdA8", 1'b1, 16'd8, 16'h0, 16'h5555, 1'b0);

    @(negedge clk);
    busA.memRq = 1'b1; busA.readNotWrite = 1'b0; busA.addr = 16'd5; busA.dataIn = 16'hAAAA;
    @(negedge clk);
    checkOutput("abort_busyInWait", busA.busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_state", dutA.r_state, mu0_mem_pkg::IDLE);
    checkOutput("abort_cnt", dutA.r_cnt, 0);
    checkOutput("abort_busy", busA.busy, 0);
    checkOutput("abort_memAck", busA.memAck, 0);
    checkOutput("abort_dataOut", busA.dataOut, 16'hBFBF);
    checkOutput("abort_ledKept", busA.led, 6'b000000);
    busA.memRq = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("rdA5", 1'b1, 16'd5, 16'h0, 16'h5555, 1'b0);

    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      busB.memRq        = 1'b1;
      busB.readNotWrite = rdV[i];
      busB.addr         = adV[i];
      busB.dataIn       = dtV[i];
      qBName.push_back($sformatf("b2b%0d", i));
      qBRd.push_back(rdV[i]);
      qBData.push_back(exV[i]);
      qBErr.push_back(1'b0);
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1 && i > 0) checkOutput($sformatf("b2b%0d_busyIdle", i), busB.busy, 0);
      end while (busB.memAck !== 1'b1 && n < 10);
      checkOutput($sformatf("b2b%0d_ack", i), busB.memAck, 1);
      checkOutput($sformatf("b2b%0d_latency", i), n, (i == 0) ? 1 : 2);
      checkOutput($sformatf("b2b%0d_busyAck", i), busB.busy, 1);
    end
    busB.memRq = 1'b0;
    @(negedge clk);
    checkOutput("b2b_busyAfter", busB.busy, 0);
    checkOutput("b2b_memAckAfter", busB.memAck, 0);

    repeat (3) @(negedge clk);
    checkOutput("sbA_empty", qAName.size(), 0);
    checkOutput("sbB_empty", qBName.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
